// File: rtl/restoring_divider.sv
// ---------------------------------------------------------------------------
// restoring_divider
//
// Sequential unsigned divider producing one quotient bit per clock. Each
// iteration shifts the partial remainder / quotient pair left by one and
// performs a trial subtraction of the divisor using a borrow-lookahead
// subtractor; the difference is kept when no borrow occurs, otherwise the
// shifted value is restored.
//
// Parameters:
//   WIDTH        operand / quotient / remainder width (2..16)
//
// Ports:
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   start        operation request, sampled only while idle
//   dividend     unsigned dividend, captured when start is accepted
//   divisor      unsigned divisor, captured when start is accepted
//   busy         high while a division is iterating
//   done         one-cycle pulse: result outputs have just been updated
//   quotient     registered quotient of the last completed operation
//   remainder    registered remainder of the last completed operation
//   div_by_zero  set when the last completed operation had a zero divisor
// ---------------------------------------------------------------------------
module restoring_divider #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t           state;
    logic [CW-1:0]    count;
    logic [WIDTH-1:0] divisor_reg;
    logic [WIDTH-1:0] qreg;

    // The (WIDTH+1)-bit partial remainder always has a zero top bit between
    // iterations (it is either restored or strictly less than the divisor),
    // so only the low WIDTH bits are stored; the shift supplies the extra bit.
    logic [WIDTH-1:0] partial_rem;

    logic [WIDTH:0]   shifted_rem;
    logic [WIDTH:0]   sub_b;
    logic [WIDTH-1:0] trial;
    logic             borrow_out;
    logic [WIDTH-1:0] next_rem;
    logic [WIDTH-1:0] next_q;

    // Borrow into bit position pos, written as a sum of products over the
    // generate/propagate terms of all lower bits rather than as a ripple
    // chain: bit j generates a borrow when a=0,b=1 and every bit between j
    // and pos propagates it (a==b).
    function automatic logic borrow_into(input logic [WIDTH:0] a,
                                         input logic [WIDTH:0] b,
                                         input int             pos);
        logic acc;
        logic term;
        acc = 1'b0;
        for (int j = 0; j < pos; j++) begin
            term = ~a[j] & b[j];
            for (int k = j + 1; k < pos; k++) begin
                term = term & ~(a[k] ^ b[k]);
            end
            acc = acc | term;
        end
        return acc;
    endfunction

    // One restoring step: shift {partial_rem, qreg} left, subtract the
    // divisor, keep the difference only if it did not go negative.
    always_comb begin
        shifted_rem = {partial_rem, qreg[WIDTH-1]};
        sub_b       = {1'b0, divisor_reg};
        trial       = '0;
        for (int i = 0; i < WIDTH; i++) begin
            trial[i] = shifted_rem[i] ^ sub_b[i] ^ borrow_into(shifted_rem, sub_b, i);
        end
        borrow_out = borrow_into(shifted_rem, sub_b, WIDTH + 1);
        next_rem   = borrow_out ? shifted_rem[WIDTH-1:0] : trial;
        next_q     = {qreg[WIDTH-2:0], ~borrow_out};
    end

    // Control FSM and datapath registers. done defaults low every cycle so
    // it can only ever be a single-cycle pulse; result outputs are written
    // solely on completion so they hold the previous answer while busy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            count       <= '0;
            divisor_reg <= '0;
            qreg        <= '0;
            partial_rem <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (divisor == '0) begin
                            // Zero divisor completes immediately without iterating.
                            quotient    <= '1;
                            remainder   <= dividend;
                            div_by_zero <= 1'b1;
                            done        <= 1'b1;
                        end else begin
                            divisor_reg <= divisor;
                            qreg        <= dividend;
                            partial_rem <= '0;
                            count       <= CW'(WIDTH);
                            busy        <= 1'b1;
                            state       <= RUN;
                        end
                    end
                end
                RUN: begin
                    partial_rem <= next_rem;
                    qreg        <= next_q;
                    count       <= count - CW'(1);
                    if (count == CW'(1)) begin
                        quotient    <= next_q;
                        remainder   <= next_rem;
                        div_by_zero <= 1'b0;
                        done        <= 1'b1;
                        busy        <= 1'b0;
                        state       <= IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: doc/restoring_divider.md
Name: restoring_divider

Overview:
- Sequential unsigned divider: quotient and remainder of two WIDTH-bit operands, one quotient bit per clock.
- Each iteration does a trial subtraction with a borrow-lookahead subtractor, the inverse operation of the team's carry-lookahead adder.
- Sits beside the adder in the arithmetic datapath; start/done handshake to the controlling FSM.

Parameters:
- WIDTH, 4, operand/quotient/remainder width in bits (legal range 2..16).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request; sampled only when not busy
- dividend  input  WIDTH  unsigned dividend, captured when start accepted
- divisor  input  WIDTH  unsigned divisor, captured when start accepted
- busy  output  1  high while an operation is in progress
- done  output  1  one-cycle pulse: results valid and updated
- quotient  output  WIDTH  registered quotient
- remainder  output  WIDTH  registered remainder
- div_by_zero  output  1  registered flag for the last completed operation

Behaviour:
- Reset (rst_n low, asynchronous):
  - busy, done, quotient, remainder and div_by_zero go to 0.
  - State goes to IDLE; iteration counter and work registers clear.
  - Reset mid-operation abandons it; no done pulse follows.
- States are IDLE and RUN. done is a registered pulse, not a state.
- IDLE, start=1, divisor!=0, at edge E0:
  - Capture operands.
  - Clear the (WIDTH+1)-bit partial remainder.
  - Load the dividend into the quotient shift register.
  - counter = WIDTH; busy=1; go to RUN.
- IDLE, start=1, divisor==0, at edge E0:
  - No RUN.
  - Set quotient = all ones, remainder = dividend, div_by_zero=1.
  - done=1 for the following cycle; busy stays 0.
- RUN, each edge:
  - Shift {partial_rem, qreg} left by 1.
  - Compute trial = shifted_rem - {1'b0, divisor} in WIDTH+1 bits.
  - No borrow: partial_rem = trial, new quotient LSB = 1.
  - Borrow: keep the shifted value, quotient LSB = 0.
  - Decrement counter.
- Last iteration (edge EW, WIDTH edges after E0):
  - Load quotient and remainder outputs (low WIDTH bits of partial_rem).
  - div_by_zero=0; done=1 for one cycle.
  - busy=0; return to IDLE.
- Latency: done is high in the cycle after edge EW. That is WIDTH cycles after the accept edge (1 cycle for divide-by-zero).
- Output registers change only on completion. Between operations and while busy, they hold the previous result.
- start while busy is ignored: no queueing and no effect on the operation in flight.
- start in the done cycle is accepted (state is already IDLE). This allows back-to-back operations with no idle gap.
- Operand inputs may change freely after the accept edge.
- Invariant for divisor!=0: dividend = quotient*divisor + remainder, remainder < divisor.
- Arithmetic is unsigned only. There is no overflow case other than divide-by-zero.

Test Plan:
- WIDTH=4: start, dividend=13, divisor=3 -> busy high 4 cycles; done pulse 4 cycles after accept; quotient=4, remainder=1, div_by_zero=0.
- Boundary values:
  - 15/1 -> q=15, r=0.
  - 2/7 -> q=0, r=2.
  - 15/15 -> q=1, r=0.
  - Exhaustive 16x15 nonzero-divisor sweep checked against the invariant.
- 9/0 -> busy never rises; done 1 cycle after accept; q=4'b1111, r=9, div_by_zero=1. Next 8/2 -> q=4, r=0, div_by_zero cleared.
- Busy-start and back-to-back:
  - Start 13/3, then pulse start with 6/2 at cycle 2 of RUN -> ignored; result is 13/3.
  - Start 6/2 during the done cycle -> accepted; q=3, r=0 exactly 4 cycles later.
- Reset mid-operation:
  - Start 14/4, drop rst_n at cycle 2 -> all outputs 0 immediately; no done pulse.
  - After release, 14/4 -> q=3, r=2.
